hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Tracks in-flight long-latency register writers in the in-order pipeline: at most one outstanding load and one outstanding mul/div.
- These are the producers whose results are not yet available on the EX/MEM bypass paths.
- Sits beside ID. Raises stall_o on RAW, WAW or structural hazards, and records each newly issued load or mul/div destination until its completion pulse.
- Completes the bypass network: the forwarding mux covers the 1-cycle ALU results; this block covers everything that cannot be forwarded in time.

Parameters:
- TIMEOUT, 1024, cycles a slot may stay pending before timeout_o latches (must be ≥2).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- id_valid_i  in  1  valid instruction in ID
- id_kind_i  in  2  destination class: KIND_ALU=0, KIND_LOAD=1, KIND_MULDIV=2, KIND_NONE=3
- id_rd_i  in  RegAddrBus  destination register
- id_rs1_i / id_rs2_i  in  RegAddrBus  source registers
- id_rs1_en_i / id_rs2_en_i  in  1  source actually read
- flush_i  in  1  kill the ID instruction this cycle
- ld_done_i  in  1  load data written back this cycle
- md_done_i  in  1  mul/div result written back this cycle
- stall_o  out  1  hold IF/ID, insert a bubble into EX
- issue_ok_o  out  1  equals id_valid_i & ~stall_o & ~flush_i
- ld_busy_o / md_busy_o  out  1  slot pending
- ld_rd_o / md_rd_o  out  RegAddrBus  pending destination (`ZeroReg when empty)
- timeout_o  out  1  sticky: a slot exceeded TIMEOUT
- spurious_o  out  1  sticky: a done pulse arrived for an empty slot
- stall_cnt_o  out  CNT_W  count of stalled cycles

Behaviour:
- Reset (rst_n=0 at a clk edge): both slots EMPTY; every output deasserted; rd outputs at `ZeroReg; counters and sticky flags cleared. Reset mid-operation discards pending slots; a later done pulse then sets spurious_o.
- Per-slot FSM with states EMPTY and PENDING. Registered fields: rd and age (sized by $clog2(TIMEOUT+1)).
  - EMPTY→PENDING on issue_ok_o with a matching kind. The slot captures id_rd_i, including x0, and sets age=0.
  - PENDING→EMPTY on the slot's done pulse.
  - Done and a new allocation in the same cycle: the slot stays PENDING with the new rd and age=0.
  - Done while EMPTY: ignored, except that spurious_o is set.
- stall_o is combinational from the registered slot state and the ID inputs. It is the OR of the following, each gated by id_valid_i:
  - RAW: for s in {rs1, rs2}, s_en=1, s≠`ZeroReg, and s equals the rd of a PENDING slot. This holds even when that slot's done is high this cycle. The stall releases the cycle after done; the value is then on the MEM/WB bypass.
  - WAW: id_kind_i≠KIND_NONE, id_rd_i≠`ZeroReg, and id_rd_i equals a PENDING slot's rd, with that slot's done low this cycle.
  - Structural: KIND_LOAD with the ld slot PENDING and ld_done_i=0, or KIND_MULDIV with the md slot PENDING and md_done_i=0. Completing the slot frees it in the same cycle.
- flush_i does not force stall_o. It suppresses issue_ok_o and therefore allocation. It never clears PENDING slots, because in-flight ops already committed.
- KIND_ALU and KIND_NONE never allocate a slot.
- age increments each cycle while PENDING, saturating at TIMEOUT. When age reaches TIMEOUT, timeout_o sets and holds until reset.
- stall_cnt_o increments when id_valid_i & stall_o & ~flush_i, saturating at all-ones.
- Latency: allocation is visible on the busy/rd outputs one cycle after issue. Hazard detection has zero latency.

Decomposition:
- Additions to type_pkg:
  - typedef IdKind (2-bit enum) with KIND_* values.
  - typedef ScbSlot (valid, rd, age).
- Use the existing `ZeroReg define.
- One sub-module, scb_slot: FSM, rd register, age/timeout logic and match compare. Instantiated twice (ld, md). The top level holds the hazard OR-logic and the counter.

Test Plan:
- Load-use: issue LOAD rd=x5; next cycle ALU rs1=x5 → stall_o=1 until ld_done_i pulses at cycle 4; stall_o=0 at cycle 5; stall_cnt_o=4.
- WAW and x0:
  - LOAD rd=x0 pending, ALU rs1=x0 → no stall.
  - MULDIV rd=x7 pending, ALU rd=x7 → stall while md_done_i=0; released in the cycle md_done_i=1.
- Structural: two back-to-back LOADs rd=x3, rd=x4 → second stalls. In the ld_done_i cycle it issues; ld_rd_o=x4 next cycle.
- Flush: LOAD rd=x9 with flush_i=1 → issue_ok_o=0, ld_busy_o stays 0. A flush during a pending MULDIV leaves md_busy_o=1.
- Timeout/spurious: TIMEOUT=8, LOAD never done → timeout_o=1 on the 9th cycle after allocation, sticky. md_done_i with md slot empty → spurious_o=1.
- Reset mid-operation: both slots pending, rst_n=0 for 1 cycle → all outputs zero; later ld_done_i → spurious_o=1.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: destination kinds and the
// per-slot view exported by each tracking slot.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef ZeroReg
`define ZeroReg 5'b00000
`endif

package hazard_scoreboard_pkg;

   localparam int RegAddrW = 5;
   localparam int ScbAgeW  = 16;

   typedef enum logic [1:0] {
      KIND_ALU    = 2'd0,
      KIND_LOAD   = 2'd1,
      KIND_MULDIV = 2'd2,
      KIND_NONE   = 2'd3
   } IdKind;

   typedef enum logic {
      SLOT_EMPTY   = 1'b0,
      SLOT_PENDING = 1'b1
   } slot_state_e;

   // age is widened to ScbAgeW here; the slot stores only $clog2(TIMEOUT+1) bits
   typedef struct packed {
      logic                valid;
      logic [RegAddrW-1:0] rd;
      logic [ScbAgeW-1:0]  age;
   } ScbSlot;

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One outstanding long-latency writer: EMPTY/PENDING FSM, destination and age
// registers, sticky timeout/spurious flags and the source/destination compares.
module scb_slot
   import hazard_scoreboard_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc,
   input  logic              done,
   input  logic [`RegAddrBus] alloc_rd,
   input  logic [`RegAddrBus] rs1,
   input  logic [`RegAddrBus] rs2,
   input  logic              rs1_en,
   input  logic              rs2_en,
   input  logic [`RegAddrBus] id_rd,
   output ScbSlot            slot,
   output logic              raw_hit,
   output logic              waw_hit,
   output logic              timeout,
   output logic              spurious
);

   localparam int               AGE_W   = $clog2(TIMEOUT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

   slot_state_e       state_q, state_d;
   logic [`RegAddrBus] rd_q, rd_d;
   logic [AGE_W-1:0]  age_q, age_d;
   logic              timeout_q, spurious_q;
   logic              pending;
   logic              rs1_hit, rs2_hit;

   assign pending = (state_q == SLOT_PENDING);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= SLOT_EMPTY;
         rd_q       <= `ZeroReg;
         age_q      <= '0;
         timeout_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         age_q      <= age_d;
         timeout_q  <= timeout_q | ((state_d == SLOT_PENDING) && (age_d == AGE_MAX));
         spurious_q <= spurious_q | (done & ~pending);
      end
   end

   // A new allocation wins over a same-cycle done: the slot restarts on the new rd
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      age_d   = age_q;
      if (state_q == SLOT_EMPTY) begin
         if (alloc) begin
            state_d = SLOT_PENDING;
            rd_d    = alloc_rd;
            age_d   = '0;
         end
      end else begin
         if (alloc) begin
            rd_d  = alloc_rd;
            age_d = '0;
         end else if (done) begin
            state_d = SLOT_EMPTY;
            rd_d    = `ZeroReg;
            age_d   = '0;
         end else if (age_q < AGE_MAX) begin
            age_d = age_q + 1'b1;
         end
      end
   end

   // RAW ignores done: the result only reaches the bypass the cycle after
   assign rs1_hit = rs1_en && (rs1 != `ZeroReg) && (rs1 == rd_q);
   assign rs2_hit = rs2_en && (rs2 != `ZeroReg) && (rs2 == rd_q);
   assign raw_hit = pending && (rs1_hit || rs2_hit);
   assign waw_hit = pending && !done && (id_rd == rd_q);

   always_comb begin
      slot       = '0;
      slot.valid = pending;
      slot.rd    = rd_q;
      slot.age   = ScbAgeW'(age_q);
   end

   assign timeout  = timeout_q;
   assign spurious = spurious_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard for the one load and one mul/div that may be in flight;
// stalls on hazards the bypass network cannot cover and counts stalled cycles.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  IdKind             id_kind_i,
   input  logic [`RegAddrBus] id_rd_i,
   input  logic [`RegAddrBus] id_rs1_i,
   input  logic [`RegAddrBus] id_rs2_i,
   input  logic              id_rs1_en_i,
   input  logic              id_rs2_en_i,
   input  logic              flush_i,
   input  logic              ld_done_i,
   input  logic              md_done_i,
   output logic              stall_o,
   output logic              issue_ok_o,
   output logic              ld_busy_o,
   output logic              md_busy_o,
   output logic [`RegAddrBus] ld_rd_o,
   output logic [`RegAddrBus] md_rd_o,
   output logic              timeout_o,
   output logic              spurious_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   ScbSlot     ld_slot, md_slot;
   logic       ld_raw, md_raw, ld_waw, md_waw;
   logic       ld_tmo, md_tmo, ld_spur, md_spur;
   logic       ld_alloc, md_alloc;
   logic       raw_haz, waw_haz, str_haz;
   logic       writes_rd;
   logic [CNT_W-1:0] stall_cnt_q;

   assign writes_rd = (id_kind_i != KIND_NONE) && (id_rd_i != `ZeroReg);

   assign raw_haz = ld_raw | md_raw;
   assign waw_haz = writes_rd && (ld_waw || md_waw);
   // A slot completing this cycle is free for the next occupant
   assign str_haz = ((id_kind_i == KIND_LOAD)   && ld_slot.valid && !ld_done_i) ||
                    ((id_kind_i == KIND_MULDIV) && md_slot.valid && !md_done_i);

   assign stall_o    = id_valid_i && (raw_haz || waw_haz || str_haz);
   assign issue_ok_o = id_valid_i && !stall_o && !flush_i;
   assign ld_alloc   = issue_ok_o && (id_kind_i == KIND_LOAD);
   assign md_alloc   = issue_ok_o && (id_kind_i == KIND_MULDIV);

   scb_slot #(.TIMEOUT(TIMEOUT)) u_ld (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc    (ld_alloc),
      .done     (ld_done_i),
      .alloc_rd (id_rd_i),
      .rs1      (id_rs1_i),
      .rs2      (id_rs2_i),
      .rs1_en   (id_rs1_en_i),
      .rs2_en   (id_rs2_en_i),
      .id_rd    (id_rd_i),
      .slot     (ld_slot),
      .raw_hit  (ld_raw),
      .waw_hit  (ld_waw),
      .timeout  (ld_tmo),
      .spurious (ld_spur)
   );

   scb_slot #(.TIMEOUT(TIMEOUT)) u_md (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc    (md_alloc),
      .done     (md_done_i),
      .alloc_rd (id_rd_i),
      .rs1      (id_rs1_i),
      .rs2      (id_rs2_i),
      .rs1_en   (id_rs1_en_i),
      .rs2_en   (id_rs2_en_i),
      .id_rd    (id_rd_i),
      .slot     (md_slot),
      .raw_hit  (md_raw),
      .waw_hit  (md_waw),
      .timeout  (md_tmo),
      .spurious (md_spur)
   );

   // Flushed cycles are not counted: the instruction is gone, not waiting
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (id_valid_i && stall_o && !flush_i && !(&stall_cnt_q))
         stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign ld_busy_o   = ld_slot.valid;
   assign md_busy_o   = md_slot.valid;
   assign ld_rd_o     = ld_slot.rd;
   assign md_rd_o     = md_slot.rd;
   assign timeout_o   = ld_tmo | md_tmo;
   assign spurious_o  = ld_spur | md_spur;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with TIMEOUT=8: load-use, WAW/x0,
// structural, flush, timeout/spurious and mid-operation reset scenarios.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        id_valid_i;
   IdKind       id_kind_i;
   logic [4:0]  id_rd_i, id_rs1_i, id_rs2_i;
   logic        id_rs1_en_i, id_rs2_en_i;
   logic        flush_i, ld_done_i, md_done_i;
   logic        stall_o, issue_ok_o, ld_busy_o, md_busy_o;
   logic [4:0]  ld_rd_o, md_rd_o;
   logic        timeout_o, spurious_o;
   logic [31:0] stall_cnt_o;

   int total = 0;
   int bad   = 0;

   hazard_scoreboard #(.TIMEOUT(8), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid_i  (id_valid_i),
      .id_kind_i   (id_kind_i),
      .id_rd_i     (id_rd_i),
      .id_rs1_i    (id_rs1_i),
      .id_rs2_i    (id_rs2_i),
      .id_rs1_en_i (id_rs1_en_i),
      .id_rs2_en_i (id_rs2_en_i),
      .flush_i     (flush_i),
      .ld_done_i   (ld_done_i),
      .md_done_i   (md_done_i),
      .stall_o     (stall_o),
      .issue_ok_o  (issue_ok_o),
      .ld_busy_o   (ld_busy_o),
      .md_busy_o   (md_busy_o),
      .ld_rd_o     (ld_rd_o),
      .md_rd_o     (md_rd_o),
      .timeout_o   (timeout_o),
      .spurious_o  (spurious_o),
      .stall_cnt_o (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      id_valid_i  = 1'b0;
      id_kind_i   = KIND_NONE;
      id_rd_i     = 5'd0;
      id_rs1_i    = 5'd0;
      id_rs2_i    = 5'd0;
      id_rs1_en_i = 1'b0;
      id_rs2_en_i = 1'b0;
      flush_i     = 1'b0;
      ld_done_i   = 1'b0;
      md_done_i   = 1'b0;
   endtask

   task automatic instr(input IdKind k, input logic [4:0] rd, input logic [4:0] rs1, input logic en1);
      id_valid_i  = 1'b1;
      id_kind_i   = k;
      id_rd_i     = rd;
      id_rs1_i    = rs1;
      id_rs1_en_i = en1;
      id_rs2_i    = 5'd0;
      id_rs2_en_i = 1'b0;
   endtask

   task automatic do_reset;
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      total++; if (ld_busy_o !== 1'b0) begin bad++; $display("FAIL rst_ld_busy got=%b want=0", ld_busy_o); end
      total++; if (md_busy_o !== 1'b0) begin bad++; $display("FAIL rst_md_busy got=%b want=0", md_busy_o); end
      total++; if (ld_rd_o !== 5'd0 || md_rd_o !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d/%0d want=0/0", ld_rd_o, md_rd_o); end
      total++; if ({stall_o, issue_ok_o, timeout_o, spurious_o} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {stall_o, issue_ok_o, timeout_o, spurious_o}); end
      total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt_o); end
   endtask

   task automatic test_load_use;
      do_reset();
      instr(KIND_LOAD, 5'd5, 5'd0, 1'b0);
      #1;
      total++; if (stall_o !== 1'b0 || issue_ok_o !== 1'b1) begin bad++; $display("FAIL lu_issue got stall=%b ok=%b want 0/1", stall_o, issue_ok_o); end
      tick();
      instr(KIND_ALU, 5'd6, 5'd5, 1'b1);
      #1;
      total++; if (ld_busy_o !== 1'b1 || ld_rd_o !== 5'd5) begin bad++; $display("FAIL lu_slot got busy=%b rd=%0d want 1/5", ld_busy_o, ld_rd_o); end
      total++; if (stall_o !== 1'b1 || issue_ok_o !== 1'b0) begin bad++; $display("FAIL lu_stall1 got stall=%b ok=%b want 1/0", stall_o, issue_ok_o); end
      tick(); tick();
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall3 got=%b want=1", stall_o); end
      tick();
      ld_done_i = 1'b1;
      #1;
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall_done got=%b want=1", stall_o); end
      tick();
      ld_done_i = 1'b0;
      #1;
      total++; if (stall_o !== 1'b0 || issue_ok_o !== 1'b1 || ld_busy_o !== 1'b0) begin bad++; $display("FAIL lu_release got stall=%b ok=%b busy=%b want 0/1/0", stall_o, issue_ok_o, ld_busy_o); end
      total++; if (stall_cnt_o !== 32'd4) begin bad++; $display("FAIL lu_cnt got=%0d want=4", stall_cnt_o); end
      tick();
      idle();
   endtask

   task automatic test_waw_x0;
      do_reset();
      instr(KIND_LOAD, 5'd0, 5'd0, 1'b0);
      tick();
      instr(KIND_ALU, 5'd0, 5'd0, 1'b1);
      #1;
      total++; if (ld_busy_o !== 1'b1 || ld_rd_o !== 5'd0) begin bad++; $display("FAIL x0_slot got busy=%b rd=%0d want 1/0", ld_busy_o, ld_rd_o); end
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL x0_nostall got=%b want=0", stall_o); end
      tick();
      idle();
      ld_done_i = 1'b1;
      tick();
      idle();
      instr(KIND_MULDIV, 5'd7, 5'd0, 1'b0);
      tick();
      instr(KIND_ALU, 5'd7, 5'd0, 1'b0);
      #1;
      total++; if (stall_o !== 1'b1 || md_rd_o !== 5'd7) begin bad++; $display("FAIL waw_stall got stall=%b md_rd=%0d want 1/7", stall_o, md_rd_o); end
      tick();
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL waw_stall2 got=%b want=1", stall_o); end
      md_done_i = 1'b1;
      #1;
      total++; if (stall_o !== 1'b0 || issue_ok_o !== 1'b1) begin bad++; $display("FAIL waw_release got stall=%b ok=%b want 0/1", stall_o, issue_ok_o); end
      tick();
      idle();
      #1;
      total++; if (md_busy_o !== 1'b0 || spurious_o !== 1'b0) begin bad++; $display("FAIL waw_after got busy=%b spur=%b want 0/0", md_busy_o, spurious_o); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      instr(KIND_LOAD, 5'd3, 5'd0, 1'b0);
      tick();
      instr(KIND_LOAD, 5'd4, 5'd0, 1'b0);
      #1;
      total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL str_stall got=%b want=1", stall_o); end
      tick();
      ld_done_i = 1'b1;
      #1;
      total++; if (stall_o !== 1'b0 || issue_ok_o !== 1'b1) begin bad++; $display("FAIL str_issue got stall=%b ok=%b want 0/1", stall_o, issue_ok_o); end
      tick();
      idle();
      #1;
      total++; if (ld_busy_o !== 1'b1 || ld_rd_o !== 5'd4 || spurious_o !== 1'b0) begin bad++; $display("FAIL str_next got busy=%b rd=%0d spur=%b want 1/4/0", ld_busy_o, ld_rd_o, spurious_o); end
      ld_done_i = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_flush;
      do_reset();
      instr(KIND_LOAD, 5'd9, 5'd0, 1'b0);
      flush_i = 1'b1;
      #1;
      total++; if (issue_ok_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL fl_issue got ok=%b stall=%b want 0/0", issue_ok_o, stall_o); end
      tick();
      idle();
      #1;
      total++; if (ld_busy_o !== 1'b0) begin bad++; $display("FAIL fl_noalloc got=%b want=0", ld_busy_o); end
      instr(KIND_MULDIV, 5'd10, 5'd0, 1'b0);
      tick();
      instr(KIND_ALU, 5'd11, 5'd10, 1'b1);
      flush_i = 1'b1;
      #1;
      total++; if (stall_o !== 1'b1 || issue_ok_o !== 1'b0) begin bad++; $display("FAIL fl_raw got stall=%b ok=%b want 1/0", stall_o, issue_ok_o); end
      tick();
      idle();
      #1;
      total++; if (md_busy_o !== 1'b1 || md_rd_o !== 5'd10) begin bad++; $display("FAIL fl_keep got busy=%b rd=%0d want 1/10", md_busy_o, md_rd_o); end
      total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL fl_cnt got=%0d want=0", stall_cnt_o); end
      md_done_i = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_timeout;
      logic exp_t;
      do_reset();
      instr(KIND_LOAD, 5'd12, 5'd0, 1'b0);
      tick();
      idle();
      for (int c = 1; c <= 9; c++) begin
         #1;
         exp_t = (c == 9);
         total++; if (timeout_o !== exp_t) begin bad++; $display("FAIL tmo_cycle%0d got=%b want=%b", c, timeout_o, exp_t); end
         tick();
      end
      ld_done_i = 1'b1;
      tick();
      idle();
      #1;
      total++; if (timeout_o !== 1'b1 || ld_busy_o !== 1'b0) begin bad++; $display("FAIL tmo_sticky got tmo=%b busy=%b want 1/0", timeout_o, ld_busy_o); end
      total++; if (spurious_o !== 1'b0) begin bad++; $display("FAIL spur_pre got=%b want=0", spurious_o); end
      md_done_i = 1'b1;
      tick();
      idle();
      #1;
      total++; if (spurious_o !== 1'b1) begin bad++; $display("FAIL spur_md got=%b want=1", spurious_o); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      instr(KIND_LOAD, 5'd1, 5'd0, 1'b0);
      tick();
      instr(KIND_MULDIV, 5'd2, 5'd0, 1'b0);
      tick();
      idle();
      #1;
      total++; if (ld_busy_o !== 1'b1 || md_busy_o !== 1'b1) begin bad++; $display("FAIL rm_both got ld=%b md=%b want 1/1", ld_busy_o, md_busy_o); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      total++; if ({ld_busy_o, md_busy_o, timeout_o, spurious_o} !== 4'b0 || ld_rd_o !== 5'd0 || md_rd_o !== 5'd0) begin bad++; $display("FAIL rm_clear got busy=%b%b tmo=%b spur=%b rd=%0d/%0d want all zero", ld_busy_o, md_busy_o, timeout_o, spurious_o, ld_rd_o, md_rd_o); end
      ld_done_i = 1'b1;
      tick();
      idle();
      #1;
      total++; if (spurious_o !== 1'b1) begin bad++; $display("FAIL rm_spur got=%b want=1", spurious_o); end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_waw_x0();
      test_back_to_back();
      test_flush();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
